// File: rtl/cobs_stream_arbiter.sv
// Packet-atomic round-robin arbiter feeding a shared COBS width-adapt/encode pipeline.
// Optional channel header beat: define COBS_ARB_CHANNEL_HEADER_EN.
module cobs_stream_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_SRC-1:0]              s_tvalid,
  input  logic [NUM_SRC-1:0]              s_tlast,
  output logic [NUM_SRC-1:0]              s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  output logic [ID_WIDTH-1:0]             m_tid,
  input  logic                            m_tready
);

  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Handshake: a beat transfers on a rising edge where valid & ready are both high;
  // valid never waits for ready, and the granted source sees m_tready directly.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef COBS_ARB_CHANNEL_HEADER_EN
    HEADER = 2'd2,
`endif
    PASS   = 2'd1
  } state_t;

  state_t        state;
  logic [GW-1:0] grant;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] next_grant;
  logic          found;

  // Search starts just after the last winner so it has lowest priority next time.
  always_comb begin
    int idx;
    idx        = 0;
    found      = 1'b0;
    next_grant = '0;
    for (int off = 1; off <= NUM_SRC; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && s_tvalid[idx]) begin
        found      = 1'b1;
        next_grant = GW'(idx);
      end
    end
  end

  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    case (state)
      PASS: begin
        m_tdata         = s_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        m_tvalid        = s_tvalid[grant];
        m_tlast         = s_tlast[grant];
        s_tready[grant] = m_tready;
      end
`ifdef COBS_ARB_CHANNEL_HEADER_EN
      HEADER: begin
        m_tdata  = DATA_WIDTH'({4'hA, 4'(grant)});
        m_tvalid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= GW'(NUM_SRC - 1);
      m_tid  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant  <= next_grant;
            rr_ptr <= next_grant;
            m_tid  <= ID_WIDTH'(next_grant);
`ifdef COBS_ARB_CHANNEL_HEADER_EN
            state  <= HEADER;
`else
            state  <= PASS;
`endif
          end
        end
`ifdef COBS_ARB_CHANNEL_HEADER_EN
        HEADER: if (m_tready) state <= PASS;
`endif
        // Grant is held until the tlast handshake, even if the source stalls.
        PASS: if (m_tvalid && m_tready && m_tlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cobs_stream_arbiter.sv
// Bench for cobs_stream_arbiter: directed table, hand-written corner sequences and a
// randomized round-robin run checked against a packet-level reference model.
module tb_cobs_stream_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] s_tdata;
  logic [N-1:0]   s_tvalid, s_tlast, s_tready;
  logic [W-1:0]   m_tdata;
  logic           m_tvalid, m_tlast, m_tready;
  logic [IW-1:0]  m_tid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] mask;
    int           tid;
    logic [W-1:0] data;
  } vec_t;
  vec_t tbl[10];

  logic [W-1:0] b1[3];
  logic [W:0]   eq[$];
  logic [W:0]   src_q[N][$];
  logic [W:0]   exp_q[N][$];

  // clock / reset
  always #5 clk = ~clk;

  cobs_stream_arbiter #(.NUM_SRC(N), .DATA_WIDTH(W), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tid(m_tid),
    .m_tready(m_tready)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_src(int i, logic v, logic [W-1:0] d, logic l);
    s_tvalid[i]       = v;
    s_tdata[i*W +: W] = d;
    s_tlast[i]        = l;
  endtask

  task automatic clear_srcs();
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
  endtask

  task automatic expect_beat(string name, logic [W-1:0] d, logic l, int tid, logic [N-1:0] rdy);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_tvalid && m_tready) && n < 30);
    if (!(m_tvalid && m_tready)) begin
      checks++;
      errors++;
      $display("FAIL %s: no beat within 30 cycles", name);
      return;
    end
    check({name, "_data"}, m_tdata, d);
    check({name, "_last"}, m_tlast, l);
    check({name, "_tid"}, m_tid, tid);
    check({name, "_ready"}, s_tready, rdy);
  endtask

  task automatic expect_hdr(string name, int tid);
`ifdef COBS_ARB_CHANNEL_HEADER_EN
    expect_beat({name, "_hdr"}, W'({4'hA, 4'(tid)}), 1'b0, tid, '0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, cur, last_src, cyc, j, pending;
    bit adv, prev_last, is_hdr;
    bit mid[N];
    logic [N-1:0] hs;
    logic [W:0] e;

    tbl[0] = '{4'b1111, 3, 8'h53};
    tbl[1] = '{4'b1111, 0, 8'h50};
    tbl[2] = '{4'b0011, 1, 8'h51};
    tbl[3] = '{4'b0001, 0, 8'h50};
    tbl[4] = '{4'b1010, 1, 8'h51};
    tbl[5] = '{4'b1001, 3, 8'h53};
    tbl[6] = '{4'b0110, 1, 8'h51};
    tbl[7] = '{4'b0100, 2, 8'h52};
    tbl[8] = '{4'b0101, 0, 8'h50};
    tbl[9] = '{4'b1000, 3, 8'h53};
    b1[0] = 8'h11; b1[1] = 8'h22; b1[2] = 8'h33;

    // reset state
    rst = 1'b1;
    m_tready = 1'b0;
    clear_srcs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tid", m_tid, 0);
    check("rst_ready", s_tready, 0);
    rst = 1'b0;

    // src2 alone, 3 beats
    m_tready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      drive_src(2, 1'b1, b1[b], b == 2);
      if (b == 0) expect_hdr("t1", 2);
      expect_beat("t1", b1[b], b == 2, 2, 4'b0100);
      step();
    end
    clear_srcs();
    @(negedge clk);
    check("t1_idle_valid", m_tvalid, 0);
    check("t1_idle_ready", s_tready, 0);
    step();

    // table of single-beat packets; each row's expectation follows from the previous winner
    foreach (tbl[v]) begin
      for (int i = 0; i < N; i++) drive_src(i, tbl[v].mask[i], W'(8'h50 + i), 1'b1);
      expect_hdr("tbl", tbl[v].tid);
      expect_beat("tbl", tbl[v].data, 1'b1, tbl[v].tid, N'(1 << tbl[v].tid));
      step();
      clear_srcs();
    end

    // src1 stalls mid-packet while src0 waits
    drive_src(0, 1'b1, 8'h60, 1'b1);
    expect_hdr("t3_pre", 0);
    expect_beat("t3_pre", 8'h60, 1'b1, 0, 4'b0001);
    step();
    drive_src(0, 1'b1, 8'h61, 1'b1);
    drive_src(1, 1'b1, 8'h71, 1'b0);
    expect_hdr("t3", 1);
    expect_beat("t3_b0", 8'h71, 1'b0, 1, 4'b0010);
    step();
    drive_src(1, 1'b0, 8'h72, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("t3_stall_valid", m_tvalid, 0);
      check("t3_stall_tid", m_tid, 1);
      check("t3_stall_ready", s_tready, 4'b0010);
    end
    step();
    drive_src(1, 1'b1, 8'h72, 1'b1);
    expect_beat("t3_b1", 8'h72, 1'b1, 1, 4'b0010);
    step();
    drive_src(1, 1'b0, 8'h00, 1'b0);
    expect_hdr("t3_src0", 0);
    expect_beat("t3_src0", 8'h61, 1'b1, 0, 4'b0001);
    step();
    clear_srcs();

    // src3 4-beat packet under a toggling m_tready
`ifdef COBS_ARB_CHANNEL_HEADER_EN
    eq.push_back({1'b0, 8'hA3});
`endif
    for (int b = 0; b < 4; b++) eq.push_back({b == 3, W'(8'hC0 + b)});
    k = 0;
    drive_src(3, 1'b1, 8'hC0, 1'b0);
    for (int c = 0; c < 40 && eq.size() > 0; c++) begin
      @(negedge clk);
      if (m_tvalid) begin
        check("t4_data", m_tdata, eq[0][W-1:0]);
        check("t4_last", m_tlast, eq[0][W]);
        check("t4_tid", m_tid, 3);
        if (m_tready) void'(eq.pop_front());
      end
      adv = s_tvalid[3] & s_tready[3];
      step();
      if (adv) k++;
      if (k < 4) drive_src(3, 1'b1, W'(8'hC0 + k), k == 3);
      else drive_src(3, 1'b0, 8'h00, 1'b0);
      m_tready = ~m_tready;
    end
    check("t4_done", eq.size(), 0);
    m_tready = 1'b1;
    clear_srcs();
    step();

    // asynchronous reset on beat 2 of a src0 packet
    drive_src(0, 1'b1, 8'hD0, 1'b0);
    expect_hdr("t5", 0);
    expect_beat("t5_b0", 8'hD0, 1'b0, 0, 4'b0001);
    step();
    drive_src(0, 1'b1, 8'hD1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", m_tvalid, 0);
    check("t5_rst_ready", s_tready, 0);
    clear_srcs();
    drive_src(1, 1'b1, 8'hE1, 1'b1);
    step();
    rst = 1'b0;
    expect_hdr("t5_src1", 1);
    expect_beat("t5_src1", 8'hE1, 1'b1, 1, 4'b0010);
    step();
    clear_srcs();

    // randomized run: every source loaded with packets, reference model tracks round robin
    rst = 1'b1;
    step();
    for (int i = 0; i < N; i++) begin
      mid[i] = 1'b0;
      for (int p = 0; p < 3; p++) begin
        k = $urandom_range(1, 4);
        for (int b = 0; b < k; b++) begin
          e = {b == k - 1, W'($urandom)};
          src_q[i].push_back(e);
          exp_q[i].push_back(e);
        end
      end
      drive_src(i, 1'b1, src_q[i][0][W-1:0], src_q[i][0][W]);
    end
    m_tready = 1'b1;
    rst = 1'b0;
    cur = -1;
    last_src = N - 1;
    prev_last = 1'b0;
    cyc = 0;
    pending = 1;
    while (pending > 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      hs = s_tvalid & s_tready;
      check("rnd_ready_onehot", $countones(s_tready) <= 1, 1);
      if (prev_last) check("rnd_bubble", m_tvalid, 0);
      prev_last = m_tvalid && m_tready && m_tlast;
      if (m_tvalid && m_tready) begin
        is_hdr = 1'b0;
        if (cur < 0) begin
          for (int off = 1; off <= N && cur < 0; off++) begin
            j = (last_src + off) % N;
            if (exp_q[j].size() > 0) cur = j;
          end
          if (cur < 0) begin
            checks++;
            errors++;
            $display("FAIL rnd_extra: unexpected beat 0x%0h tid %0d", m_tdata, m_tid);
          end else begin
            check("rnd_grant_tid", m_tid, cur);
`ifdef COBS_ARB_CHANNEL_HEADER_EN
            check("rnd_hdr_data", m_tdata, W'({4'hA, 4'(cur)}));
            check("rnd_hdr_last", m_tlast, 0);
            is_hdr = 1'b1;
`endif
          end
        end
        if (cur >= 0 && !is_hdr) begin
          e = exp_q[cur].pop_front();
          check("rnd_data", m_tdata, e[W-1:0]);
          check("rnd_last", m_tlast, e[W]);
          check("rnd_tid", m_tid, cur);
          if (e[W]) begin
            last_src = cur;
            cur = -1;
          end
        end
      end
      step();
      pending = (cur >= 0) ? 1 : 0;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && src_q[i].size() > 0) begin
          e = src_q[i].pop_front();
          mid[i] = !e[W];
        end
        if (src_q[i].size() > 0) begin
          drive_src(i, mid[i] ? ($urandom_range(0, 3) != 0) : 1'b1,
                    src_q[i][0][W-1:0], src_q[i][0][W]);
        end else begin
          drive_src(i, 1'b0, 8'h00, 1'b0);
        end
        pending += exp_q[i].size();
      end
      m_tready = ($urandom_range(0, 3) != 0);
    end
    check("rnd_all_delivered", pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
